// File: rtl/ec_ctrl_pkg.sv
// Types and helpers for the encoder control blocks.
//   outbuf_state_t : output-buffer controller FSM states
//   OFF_W          : beat-offset field width of the outbuf address
//   clamp_m        : maps a raw MReg value onto the legal range 1..m_max
package ec_ctrl_pkg;

  import global_parameters::*;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } outbuf_state_t;

  localparam int unsigned OFF_W = OUTBUF_MEM_ADDR_W - $clog2(M_MAX);

  function automatic int unsigned clamp_m(int unsigned m, int unsigned m_max);
    if (m == 0) begin
      return 1;
    end else if (m > m_max) begin
      return m_max;
    end
    return m;
  endfunction

endpackage

// File: rtl/global_parameters.sv
// Global constants shared by the encoder datapath.
//   DATA_W            : width of one parity word and of one outbuf memory word
//   M_MAX             : maximum parity rows carried per beat (power of 2, >= 2)
//   OUTBUF_MEM_ADDR_W : outbuf memory address width
package global_parameters;

  localparam int unsigned DATA_W            = 32;
  localparam int unsigned M_MAX             = 4;
  localparam int unsigned OUTBUF_MEM_ADDR_W = 10;

endpackage

// File: rtl/outbuf_fifo.sv
// Synchronous beat FIFO.
//   clk   : clock
//   flush : synchronous clear (empties the FIFO)
//   push  : write din (ignored while full)
//   pop   : drop head entry (ignored while empty)
//   din   : entry to write
//   dout  : head entry
//   full  : Depth entries held (registered count, no push->full comb path)
//   empty : no entries held
module outbuf_fifo #(
  parameter int unsigned Width = 128,
  parameter int unsigned Depth = 2
) (
  input  logic             clk,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [Width-1:0] din,
  output logic [Width-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PtrW = $clog2(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]    cnt_q;
  logic             do_push, do_pop;

  assign full    = (cnt_q == (PtrW + 1)'(Depth));
  assign empty   = (cnt_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Storage needs no reset: reads are only meaningful while non-empty.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/outbuff_cntl.sv
// Output-buffer controller. Buffers parity beats from the encoding engine and
// serialises the active rows of each beat into one-word outbuf memory writes.
//   clk, rst                 : clock, sync active-high reset
//   eng_rst                  : sync soft clear from the engine FSM (same effect as rst)
//   cntrl_outbuff_wr_en      : engine permits beat acceptance
//   MReg, BlkLenReg          : rows per beat, beats per frame (0 = 2^OFF_W); latched per frame
//   eng_outbuf_data(_val)    : beat and its valid; outbuf_eng_data_rdy accepts it
//   outbuf_mem_wr_*          : memory write request/address/data, accepted on req && rdy
//   outbuf_cntl_busy/done/err: status, one-cycle frame-done pulse, sticky protocol error
module outbuff_cntl
  import ec_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W            = global_parameters::DATA_W,
  parameter int unsigned M_MAX             = global_parameters::M_MAX,
  parameter int unsigned OUTBUF_MEM_ADDR_W = global_parameters::OUTBUF_MEM_ADDR_W,
  parameter int unsigned FIFO_DEPTH        = 2,
  localparam int unsigned RowW             = $clog2(M_MAX),
  localparam int unsigned OffW             = OUTBUF_MEM_ADDR_W - RowW
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         eng_rst,
  input  logic                         cntrl_outbuff_wr_en,
  input  logic [RowW:0]                MReg,
  input  logic [OffW-1:0]              BlkLenReg,
  input  logic [M_MAX*DATA_W-1:0]      eng_outbuf_data,
  input  logic                         eng_outbuf_data_val,
  output logic                         outbuf_eng_data_rdy,
  output logic                         outbuf_mem_wr_req,
  output logic [OUTBUF_MEM_ADDR_W-1:0] outbuf_mem_wr_addr,
  output logic [DATA_W-1:0]            outbuf_mem_wr_data,
  input  logic                         outbuf_mem_wr_rdy,
  output logic                         outbuf_cntl_busy,
  output logic                         outbuf_cntl_done,
  output logic                         outbuf_cntl_err
);

  outbuf_state_t         state_q, state_d;
  logic [RowW-1:0]       row_q, row_d;
  logic [OffW-1:0]       off_q, off_d;
  logic [RowW-1:0]       m_last_q;   // m_eff - 1
  logic [OffW-1:0]       blk_q;
  logic                  err_q;

  logic                  fifo_full, fifo_empty;
  logic [M_MAX*DATA_W-1:0] head;
  logic                  push, pop, wr_fire, last_row, last_beat, latch_cfg;
  logic [OffW-1:0]       blk_last;

  assign outbuf_eng_data_rdy = cntrl_outbuff_wr_en && !fifo_full && (state_q != DONE);
  assign push      = eng_outbuf_data_val && outbuf_eng_data_rdy;
  assign outbuf_mem_wr_req = (state_q == WRITE) && !fifo_empty;
  assign wr_fire   = outbuf_mem_wr_req && outbuf_mem_wr_rdy;
  assign last_row  = (row_q == m_last_q);
  assign pop       = wr_fire && last_row;
  // BlkLenReg = 0 wraps to all-ones here, i.e. a full 2^OffW region.
  assign blk_last  = blk_q - OffW'(1);
  assign last_beat = (off_q == blk_last);
  assign latch_cfg = (state_q == IDLE) && push;

  assign outbuf_mem_wr_addr = {row_q, off_q};
  assign outbuf_mem_wr_data = outbuf_mem_wr_req ? head[row_q*DATA_W +: DATA_W] : '0;
  assign outbuf_cntl_busy   = !fifo_empty || (state_q != IDLE);
  assign outbuf_cntl_done   = (state_q == DONE);
  assign outbuf_cntl_err    = err_q;

  outbuf_fifo #(
    .Width (M_MAX*DATA_W),
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .flush (rst || eng_rst),
    .push  (push),
    .pop   (pop),
    .din   (eng_outbuf_data),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    off_d   = off_q;
    unique case (state_q)
      IDLE: begin
        // Leaving on the push itself gives the first write one cycle after acceptance.
        if (push || !fifo_empty) state_d = WRITE;
      end
      WRITE: begin
        if (wr_fire) begin
          if (last_row) begin
            row_d = '0;
            if (last_beat) begin
              off_d   = '0;
              state_d = DONE;
            end else begin
              off_d = off_q + 1'b1;
            end
          end else begin
            row_d = row_q + 1'b1;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || eng_rst) begin
      state_q  <= IDLE;
      row_q    <= '0;
      off_q    <= '0;
      m_last_q <= '0;
      blk_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      off_q   <= off_d;
      if (latch_cfg) begin
        m_last_q <= RowW'(clamp_m(int'(MReg), M_MAX) - 1);
        blk_q    <= BlkLenReg;
      end
      if (eng_outbuf_data_val && !cntrl_outbuff_wr_en) err_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_outbuff_cntl.sv
module tb_outbuff_cntl;
  import ec_ctrl_pkg::*;

  logic         clk = 1'b0;
  logic         rst, eng_rst, wr_en, val, mem_rdy;
  logic [2:0]   mreg;
  logic [7:0]   blklen;
  logic [127:0] beat;
  logic         rdy, req, busy, done, err;
  logic [9:0]   addr;
  logic [31:0]  wdata;

  always #5 clk = ~clk;

  outbuff_cntl dut (
    .clk                 (clk),
    .rst                 (rst),
    .eng_rst             (eng_rst),
    .cntrl_outbuff_wr_en (wr_en),
    .MReg                (mreg),
    .BlkLenReg           (blklen),
    .eng_outbuf_data     (beat),
    .eng_outbuf_data_val (val),
    .outbuf_eng_data_rdy (rdy),
    .outbuf_mem_wr_req   (req),
    .outbuf_mem_wr_addr  (addr),
    .outbuf_mem_wr_data  (wdata),
    .outbuf_mem_wr_rdy   (mem_rdy),
    .outbuf_cntl_busy    (busy),
    .outbuf_cntl_done    (done),
    .outbuf_cntl_err     (err)
  );

  // Reference model: a queue of the writes the frame must produce, plus counts.
  typedef struct {
    logic [9:0]  addr;
    logic [31:0] data;
    bit          last_beat;
    bit          last_frame;
  } wr_t;

  wr_t        expq[$];
  logic [9:0] wlog[$];
  int         occ, m_m, m_blk, m_beat;
  bit         m_done, m_in_frame, m_err;
  bit         prev_stall;
  logic [9:0] prev_addr;
  logic [31:0] prev_data;
  bit         acc, wfire, last_done;
  int         done_cnt;
  int         n_vec, n_err;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] rand_beat();
    logic [127:0] b;
    for (int i = 0; i < 4; i++) b[i*32 +: 32] = $urandom;
    return b;
  endfunction

  // One clock: check outputs against the model, then advance the model at the edge.
  task automatic tick();
    wr_t w;
    bit  nd;
    #1;
    chk("rdy", rdy, wr_en && (occ < 2) && !m_done);
    chk("done", done, m_done);
    chk("busy", busy, (occ > 0) || m_in_frame || m_done);
    chk("err", err, m_err);
    chk("req", req, occ > 0);
    if (req) begin
      if (expq.size() == 0) chk("unexpected_write", req, 0);
      else begin
        chk("wr_addr", addr, expq[0].addr);
        chk("wr_data", wdata, expq[0].data);
      end
    end
    if (prev_stall) begin
      chk("hold_req", req, 1);
      chk("hold_addr", addr, prev_addr);
      chk("hold_data", wdata, prev_data);
    end
    acc        = val && rdy;
    wfire      = req && mem_rdy;
    last_done  = done;
    if (done) done_cnt++;
    if (wfire) wlog.push_back(addr);
    prev_stall = req && !mem_rdy && !rst && !eng_rst;
    prev_addr  = addr;
    prev_data  = wdata;
    @(posedge clk);
    if (rst || eng_rst) begin
      expq.delete();
      occ = 0; m_done = 0; m_in_frame = 0; m_err = 0;
    end else begin
      nd = 0;
      if (wfire && expq.size() > 0) begin
        w = expq.pop_front();
        if (w.last_beat) occ--;
        if (w.last_frame) begin
          nd = 1;
          m_in_frame = 0;
        end
      end
      if (acc) begin
        if (!m_in_frame) begin
          m_m        = (mreg == 0) ? 1 : (mreg > 4) ? 4 : int'(mreg);
          m_blk      = (blklen == 0) ? (1 << OFF_W) : int'(blklen);
          m_beat     = 0;
          m_in_frame = 1;
        end
        for (int r = 0; r < m_m; r++) begin
          w.addr       = 10'((r << OFF_W) | m_beat);
          w.data       = beat[r*32 +: 32];
          w.last_beat  = (r == m_m - 1);
          w.last_frame = (r == m_m - 1) && (m_beat == m_blk - 1);
          expq.push_back(w);
        end
        m_beat++;
        occ++;
      end
      m_done = nd;
      if (val && !wr_en) m_err = 1;
    end
    @(negedge clk);
  endtask

  task automatic soft_clear();
    val     = 0;
    eng_rst = 1;
    tick();
    eng_rst = 0;
  endtask

  // rdy_mode: 0 = always ready, 1 = toggling 1010, 2 = random.
  task automatic run_frame(input int mr, input int bl, input int nb, input int rdy_mode,
                           input int mr_mid, input bit gaps);
    int sent = 0;
    int cyc  = 0;
    bit seen = 0;
    wlog.delete();
    mreg   = 3'(mr);
    blklen = 8'(bl);
    beat   = rand_beat();
    while (!seen && cyc < 3000) begin
      val     = (sent < nb) && (!gaps || $urandom_range(0, 3) != 0);
      mem_rdy = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 1) ? ((cyc % 2) == 0)
                                       : 1'($urandom_range(0, 1));
      tick();
      if (acc) begin
        sent++;
        if (sent == 1) mreg = 3'(mr_mid);
        beat = rand_beat();
      end
      if (last_done) seen = 1;
      cyc++;
    end
    val     = 0;
    mem_rdy = 1;
    chk("frame_done_seen", seen, 1);
    if (!seen) soft_clear();
    tick();
    chk("queue_drained", expq.size(), 0);
  endtask

  int sent, wc, budget, bl;

  initial begin
    rst = 1; eng_rst = 0; wr_en = 0; val = 0; mem_rdy = 1;
    mreg = 0; blklen = 0; beat = '0;
    occ = 0; m_done = 0; m_in_frame = 0; m_err = 0; prev_stall = 0;
    n_vec = 0; n_err = 0; done_cnt = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 0;
    #1;
    chk("rst_rdy", rdy, 0);
    chk("rst_req", req, 0);
    chk("rst_addr", addr, 0);
    chk("rst_data", wdata, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    @(negedge clk);
    wr_en = 1;

    // M=2, BlkLen=3, always ready, back-to-back.
    run_frame(2, 3, 3, 0, 2, 0);
    chk("t1_nwrites", wlog.size(), 6);
    if (wlog.size() == 6) begin
      chk("t1_a0", wlog[0], 10'h000);
      chk("t1_a1", wlog[1], 10'h100);
      chk("t1_a2", wlog[2], 10'h001);
      chk("t1_a3", wlog[3], 10'h101);
      chk("t1_a4", wlog[4], 10'h002);
      chk("t1_a5", wlog[5], 10'h102);
    end

    // M=4, memory ready toggling.
    run_frame(4, 3, 3, 1, 4, 0);
    chk("t2_nwrites", wlog.size(), 12);

    // MReg clamping and mid-frame change ignored.
    run_frame(0, 2, 2, 0, 7, 0);
    chk("t3_m0_writes", wlog.size(), 2);
    run_frame(7, 2, 2, 0, 0, 0);
    chk("t3_m7_writes", wlog.size(), 8);

    // Valid while not enabled: sticky error until soft clear.
    wr_en = 0; val = 1; beat = rand_beat();
    tick(); tick();
    val = 0; wr_en = 1;
    tick();
    chk("t4_err_set", err, 1);
    run_frame(1, 2, 2, 0, 1, 0);
    chk("t4_err_sticky", err, 1);
    soft_clear();
    chk("t4_err_cleared", err, 0);

    // Soft clear after the second word of a 3-beat frame.
    mreg = 2; blklen = 3; beat = rand_beat(); sent = 0; wc = 0; budget = 0;
    while (wc < 2 && budget < 100) begin
      val = (sent < 3); mem_rdy = 1;
      tick();
      if (acc) begin sent++; beat = rand_beat(); end
      if (wfire) wc++;
      budget++;
    end
    chk("t5_two_words", wc, 2);
    done_cnt = 0;
    soft_clear();
    #1;
    chk("t5_req_withdrawn", req, 0);
    chk("t5_busy_clear", busy, 0);
    chk("t5_no_done", done, 0);
    @(negedge clk);
    tick();
    chk("t5_no_done_pulse", done_cnt, 0);
    run_frame(2, 3, 3, 0, 2, 0);
    if (wlog.size() > 0) chk("t5_restart_off0", wlog[0], 10'h000);

    // BlkLen=0 means a full 256-beat region.
    done_cnt = 0;
    run_frame(1, 0, 256, 0, 1, 0);
    chk("t6_nwrites", wlog.size(), 256);
    if (wlog.size() == 256) begin
      chk("t6_first", wlog[0], 10'h000);
      chk("t6_last", wlog[255], 10'h0FF);
    end
    chk("t6_single_done", done_cnt, 1);

    // Randomised frames: random M, length, back-pressure and valid gaps.
    for (int f = 0; f < 8; f++) begin
      bl = $urandom_range(1, 5);
      run_frame($urandom_range(0, 7), bl, bl, 2, $urandom_range(0, 7), 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
